// File: rtl/mem_design_pkg.sv
// Shared types and default parameters for the memory CAM subsystem.
package mem_design_pkg;

  localparam int unsigned param_WIDTH_DATA  = 8;
  localparam int unsigned param_WIDTH_ADDR  = 4;
  localparam int unsigned param_SEQ_DEPTH   = 4;
  localparam int unsigned param_SEQ_TIMEOUT = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } seq_state_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Small synchronous command FIFO with power-of-2 depth and naturally wrapping pointers.
module mem_cmd_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push_c && !do_pop_c)      count <= count + CW'(1);
      else if (do_pop_c && !do_push_c) count <= count - CW'(1);
    end
  end

  // Payload storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_cmd_sequencer.sv
// Buffers client read/write commands and issues them one at a time on the CAM
// req/busy handshake, returning exactly one ordered response per command.
module mem_cmd_sequencer
  import mem_design_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = param_WIDTH_DATA,
  parameter int unsigned WIDTH_ADDR = param_WIDTH_ADDR,
  parameter int unsigned DEPTH      = param_SEQ_DEPTH,
  parameter int unsigned TIMEOUT    = param_SEQ_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_nrd,
  input  logic [WIDTH_ADDR-1:0] cmd_addr,
  input  logic [WIDTH_DATA-1:0] cmd_din,
  output logic                  cam_req,
  output logic                  cam_wr_nrd,
  output logic [WIDTH_ADDR-1:0] cam_addr,
  output logic [WIDTH_DATA-1:0] cam_din,
  input  logic                  cam_busy,
  input  logic                  cam_read_valid,
  input  logic [WIDTH_DATA-1:0] cam_dout,
  input  logic                  cam_write_error,
  output logic                  rsp_valid,
  output logic                  rsp_wr,
  output logic [WIDTH_DATA-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic [7:0]            err_count
);

  localparam int unsigned PW      = 1 + WIDTH_ADDR + WIDTH_DATA;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  seq_state_t    state;
  logic [7:0]    tcnt;
  logic [PW-1:0] head;
  logic          full;
  logic          empty;
  logic          push_c;
  logic          pop_c;

  assign cmd_ready = !full;
  assign push_c    = cmd_valid && !full;
  assign pop_c     = (state == S_IDLE) && !empty && !cam_busy;

  mem_cmd_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   ({cmd_wr_nrd, cmd_addr, cmd_din}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      cam_req     <= 1'b0;
      cam_wr_nrd  <= 1'b0;
      cam_addr    <= '0;
      cam_din     <= '0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop_c) begin
            {cam_wr_nrd, cam_addr, cam_din} <= head;
            cam_req <= 1'b1;
            tcnt    <= '0;
            state   <= S_REQ;
          end
        end
        // tcnt != 0 keeps req high for at least two cycles.
        S_REQ: begin
          if (tcnt == TO_LAST) begin
            cam_req     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_wr      <= cam_wr_nrd;
            rsp_data    <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= S_RESP;
          end else begin
            if (cam_busy && (tcnt != 8'd0)) begin
              cam_req <= 1'b0;
              state   <= S_WAIT;
            end
            tcnt <= tcnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (tcnt == TO_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_wr      <= cam_wr_nrd;
            rsp_data    <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= S_RESP;
          end else if (!cam_busy) begin
            rsp_valid   <= 1'b1;
            rsp_wr      <= cam_wr_nrd;
            rsp_data    <= (!cam_wr_nrd && cam_read_valid) ? cam_dout : '0;
            rsp_error   <= cam_wr_nrd && cam_write_error;
            rsp_timeout <= 1'b0;
            state       <= S_RESP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_error && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
          rsp_valid   <= 1'b0;
          rsp_wr      <= 1'b0;
          rsp_data    <= '0;
          rsp_error   <= 1'b0;
          rsp_timeout <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
